// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-path constants and types: word size, fetch FSM states,
// and the {pc, inst} entry carried by the instruction buffer.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

    // Clear the byte-offset bits so every PC is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head entry is always visible on head_data.
// Storage is cleared on reset so head_data reads zero until the first push.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word fetches over req/gnt/rvalid,
// buffers returned words with their PC and hands them to decode via valid/ready.
module inst_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [CW-1:0]   outst_q;
    logic [CW-1:0]   outst_d;

    logic            grant;
    logic            resp;
    logic            pop;
    logic            push;
    logic            redir;
    logic [CW-1:0]   occ;
    logic            ibuf_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic [XLEN-1:0] tag_pc;

    logic            ibuf_full_unused;
    logic            tag_full_unused;
    logic            tag_empty_unused;
    logic [CW-1:0]   tag_count_unused;

    assign redir = redirect & (state_q != BOOT);
    assign pop   = inst_valid & inst_ready;
    assign grant = imem_req & imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp  = imem_rvalid & (outst_q != '0);
    assign push  = resp & (state_q == FETCH) & ~redir;

    // Issue only while buffered + in-flight words (minus this cycle's pop) leave room.
    assign imem_req = (state_q == FETCH) &&
                      ((32'(occ) + 32'(outst_q)) < (FIFO_DEPTH + 32'(pop)));

    assign imem_addr  = pc_q;
    assign inst_valid = ~ibuf_empty;
    assign inst       = head_entry.inst;
    assign inst_pc    = head_entry.pc;

    assign push_entry.pc   = tag_pc;
    assign push_entry.inst = imem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
        end
    end

    // Next state, next PC and in-flight count; redirect overrides a same-cycle grant.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        outst_d = outst_q + CW'(grant) - CW'(resp);

        unique case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            DRAIN:   if (outst_d == '0) state_d = FETCH;
            default: state_d = BOOT;
        endcase

        if (grant) begin
            pc_d = pc_q + XLEN'(INST_BYTES);
        end

        if (redir) begin
            pc_d    = word_align(redirect_pc);
            state_d = (outst_d != '0) ? DRAIN : FETCH;
        end
    end

    fetch_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redir),
        .head_data (head_entry),
        .full      (ibuf_full_unused),
        .empty     (ibuf_empty),
        .count     (occ)
    );

    // PC of each granted fetch, popped as its response returns (never flushed).
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tagq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (pc_q),
        .pop       (resp),
        .flush     (1'b0),
        .head_data (tag_pc),
        .full      (tag_full_unused),
        .empty     (tag_empty_unused),
        .count     (tag_count_unused)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a 1-cycle memory model answers grants,
// a PC model predicts every delivered {pc, inst}, redirects discard predictions.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int unsigned DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] model_pc;
    logic        mem_hold;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc;
    int          first_gnt_cyc;
    int          first_val_cyc;
    int          n_gnt;
    int          n_pop;
    logic        ok;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Mid-cycle monitor: scoreboard pops, grant address check, PC model update.
    task automatic sample();
        logic g;
        logic p;
        exp_t e;
        @(negedge clk);
        if (!rst_n) return;
        cyc++;
        g = imem_req & imem_gnt;
        p = inst_valid & inst_ready;
        if (g && first_gnt_cyc < 0) first_gnt_cyc = cyc;
        if (inst_valid && first_val_cyc < 0) first_val_cyc = cyc;
        if (g) n_gnt++;
        if (p) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                chk("spurious_pop", 64'(p), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", 64'(inst_pc), 64'(e.pc));
                chk("inst", 64'(inst), 64'(e.inst));
            end
        end
        if (g) chk("gnt_addr", 64'(imem_addr), 64'(model_pc));
        if (imem_rvalid && rsp_q.size() > 0) void'(rsp_q.pop_front());
        if (g) rsp_q.push_back(imem_addr);
        if (redirect) begin
            exp_q.delete();
            model_pc = redirect_pc & ~32'h3;
        end else if (g) begin
            e.pc   = model_pc;
            e.inst = mem_word(model_pc);
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
        end
        chk("inflight_bound", 64'(exp_q.size() <= DEPTH), 64'(1));
    endtask

    // Clock edge, then memory model drives the oldest pending response.
    task automatic advance();
        @(posedge clk);
        #1;
        if (!mem_hold && rsp_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(rsp_q[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; mem_hold = 1'b0;
        model_pc = RESET_PC; cyc = 0; first_gnt_cyc = -1; first_val_cyc = -1;
        n_gnt = 0; n_pop = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_addr", 64'(imem_addr), 64'(RESET_PC));
        chk("rst_valid", 64'(inst_valid), 64'(0));
        chk("rst_inst", 64'(inst), 64'(0));
        chk("rst_pc", 64'(inst_pc), 64'(0));

        // Streaming with a 1-cycle memory and decode always ready
        imem_gnt = 1'b1; inst_ready = 1'b1;
        rst_n = 1'b1;
        sample(); chk("boot_req", 64'(imem_req), 64'(0)); advance();
        for (int i = 0; i < 12; i++) begin
            if (i == 4) n_pop = 0;
            step();
        end
        chk("first_latency", 64'(first_val_cyc - first_gnt_cyc), 64'(2));
        chk("back_to_back_pops", 64'(n_pop), 64'(8));

        // Decode stalls for 10 cycles
        inst_ready = 1'b0; n_gnt = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("stall_valid", 64'(inst_valid), 64'(1));
            chk("stall_head_pc", 64'(inst_pc), 64'((exp_q.size() > 0) ? exp_q[0].pc : 32'hDEAD_BEEF));
            chk("stall_head_inst", 64'(inst), 64'((exp_q.size() > 0) ? exp_q[0].inst : 32'hDEAD_BEEF));
            advance();
        end
        chk("stall_grants", 64'(n_gnt <= DEPTH), 64'(1));
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 64'(imem_req), 64'(0));
        chk("mid_rst_addr", 64'(imem_addr), 64'(RESET_PC));
        chk("mid_rst_valid", 64'(inst_valid), 64'(0));
        chk("mid_rst_inst", 64'(inst), 64'(0));
        chk("mid_rst_pc", 64'(inst_pc), 64'(0));
        rsp_q.delete(); exp_q.delete(); model_pc = RESET_PC;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        sample(); chk("boot_req2", 64'(imem_req), 64'(0)); advance();

        // Grant withheld for 3 cycles after the first fetch
        step();
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("hold_req", 64'(imem_req), 64'(1));
            chk("hold_addr", 64'(imem_addr), 64'(32'h104));
            advance();
        end
        imem_gnt = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Redirect with two fetches in flight
        mem_hold = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            sample();
            ok = (rsp_q.size() == 2) && !inst_valid;
            advance();
        end
        chk("two_in_flight", 64'(ok), 64'(1));
        redirect = 1'b1; redirect_pc = 32'h203;
        sample();
        mem_hold = 1'b0;
        advance();
        redirect = 1'b0;
        sample();
        chk("drain_req", 64'(imem_req), 64'(0));
        chk("drain_valid", 64'(inst_valid), 64'(0));
        advance();
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            sample();
            ok = imem_req & imem_gnt;
            advance();
        end
        chk("refetch_granted", 64'(ok), 64'(1));
        for (int i = 0; i < 6; i++) step();

        // Redirect in the same cycle as a pop and a grant
        redirect = 1'b1; redirect_pc = 32'h400;
        sample();
        chk("redir_pop", 64'(inst_valid & inst_ready), 64'(1));
        chk("redir_gnt", 64'(imem_req & imem_gnt), 64'(1));
        advance();
        redirect = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // PC wrap past the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Stop issuing and let everything in flight drain out
        imem_gnt = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
